// File: rtl/note_pkg.sv
// Shared types and constants for the note hit detector.
package note_pkg;

  localparam int N_SLOTS = 32;
  localparam int NOTE_XW = 10;
  localparam int SCORE_W = 16;
  localparam logic [NOTE_XW-1:0] NOTE_INACTIVE = 10'd0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_SCAN   = 2'd2,
    ST_REPORT = 2'd3
  } state_e;

endpackage

// File: rtl/popcount32.sv
// Combinational population count of a 32-bit vector.
module popcount32 (
  input  logic [31:0] bits_in,
  output logic [5:0]  count
);

  // Sum the set bits.
  always_comb begin
    count = 6'd0;
    for (int i = 0; i < 32; i++) begin
      count = count + {5'd0, bits_in[i]};
    end
  end

endmodule

// File: rtl/note_hit_detector.sv
// Scans 32 note slots per frame against a latched cursor and scores overlaps.
// Optional macro NOTE_HIT_EDGE_EN: score only slots that were not already hit last scan.
module note_hit_detector
  import note_pkg::*;
#(
  parameter logic [9:0] TOL     = 10'd16,
  parameter int         N_SLOTS = 32
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic [5:0]           slot_cnt,
  input  logic [NOTE_XW-1:0]   note_x,
  input  logic                 frame_start,
  input  logic [NOTE_XW-1:0]   cursor_x,
  input  logic                 cursor_valid,
  output logic [N_SLOTS-1:0]   hit_mask,
  output logic                 hit_valid,
  output logic [SCORE_W-1:0]   score,
  output logic                 busy
);

  state_e               state_r;
  state_e               state_nxt_s;
  logic [N_SLOTS-1:0]   scratch_r;
  logic [N_SLOTS-1:0]   scratch_nxt_s;
  logic [N_SLOTS-1:0]   new_hits_s;
  logic [NOTE_XW-1:0]   cur_x_r;
  logic                 cur_v_r;
  logic [N_SLOTS-1:0]   hit_mask_r;
  logic                 hit_valid_r;
  logic [SCORE_W-1:0]   score_r;
  logic [SCORE_W-1:0]   score_nxt_s;
  logic                 busy_r;
  logic [4:0]           aligned_s;
  logic [NOTE_XW:0]     diff_s;
  logic                 hit_s;
  logic                 sample_s;
  logic                 last_s;
  logic [5:0]           pop_s;
  logic [SCORE_W:0]     sum_s;

  // note_x lags slot_cnt by one, so the slot being presented is slot_cnt - 1.
  assign aligned_s = 5'(slot_cnt - 6'd1);

  // Overlap test with an 11-bit unsigned magnitude so nothing wraps.
  always_comb begin
    if ({1'b0, note_x} >= {1'b0, cur_x_r}) begin
      diff_s = {1'b0, note_x} - {1'b0, cur_x_r};
    end else begin
      diff_s = {1'b0, cur_x_r} - {1'b0, note_x};
    end
    hit_s = cur_v_r && (note_x != NOTE_INACTIVE) && (diff_s <= {1'b0, TOL});
  end

  // Sampling window: the ARM cycle that sees slot 0, then every SCAN cycle.
  always_comb begin
    sample_s      = ((state_r == ST_ARM) && (aligned_s == 5'd0)) || (state_r == ST_SCAN);
    last_s        = (state_r == ST_SCAN) && (aligned_s == 5'd31);
    scratch_nxt_s = scratch_r;
    if (sample_s) begin
      scratch_nxt_s[aligned_s] = hit_s;
    end else begin
      scratch_nxt_s = scratch_r;
    end
  end

  // Next-state decode; frame_start is only honoured in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:   if (frame_start) state_nxt_s = ST_ARM;
                 else             state_nxt_s = ST_IDLE;
      ST_ARM:    if (aligned_s == 5'd0) state_nxt_s = ST_SCAN;
                 else                   state_nxt_s = ST_ARM;
      ST_SCAN:   if (aligned_s == 5'd31) state_nxt_s = ST_REPORT;
                 else                    state_nxt_s = ST_SCAN;
      ST_REPORT: state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

`ifdef NOTE_HIT_EDGE_EN
  assign new_hits_s = scratch_nxt_s & ~hit_mask_r;
`else
  assign new_hits_s = scratch_nxt_s;
`endif

  popcount32 u_popcount (
    .bits_in (new_hits_s),
    .count   (pop_s)
  );

  // Saturating score accumulation.
  always_comb begin
    sum_s = {1'b0, score_r} + {11'd0, pop_s};
    if (sum_s[SCORE_W]) begin
      score_nxt_s = 16'hFFFF;
    end else begin
      score_nxt_s = sum_s[SCORE_W-1:0];
    end
  end

  // State, cursor latch, scratch mask and registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      scratch_r   <= '0;
      cur_x_r     <= 10'd0;
      cur_v_r     <= 1'b0;
      hit_mask_r  <= '0;
      hit_valid_r <= 1'b0;
      score_r     <= 16'd0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      busy_r      <= (state_nxt_s == ST_ARM) || (state_nxt_s == ST_SCAN);
      hit_valid_r <= last_s;
      if ((state_r == ST_IDLE) && frame_start) begin
        cur_x_r   <= cursor_x;
        cur_v_r   <= cursor_valid;
        scratch_r <= '0;
      end else if (sample_s) begin
        scratch_r <= scratch_nxt_s;
      end
      // Results land on the edge into REPORT so hit_valid is high during REPORT.
      if (last_s) begin
        hit_mask_r <= scratch_nxt_s;
        score_r    <= score_nxt_s;
      end
    end
  end

  assign hit_mask  = hit_mask_r;
  assign hit_valid = hit_valid_r;
  assign score     = score_r;
  assign busy      = busy_r;

endmodule

// File: doc/note_hit_detector.md
NOTE_HIT_DETECTOR -- requirements
Module: note_hit_detector

Interface
REQ-001 Parameter TOL, default 10'd16: max |note_x - cursor_x| counted as overlap.
REQ-002 Parameter N_SLOTS, default 32: note slots per scan; fixed at 32 in this revision.
REQ-003 clk_in  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 slot_cnt  input  6  slot counter from the note mux; after each edge it is one ahead of note_x.
REQ-006 note_x  input  10  registered note x position; 10'd0 means slot inactive.
REQ-007 frame_start  input  1  one-cycle pulse; requests one scan.
REQ-008 cursor_x  input  10  tracked red-object x coordinate.
REQ-009 cursor_valid  input  1  cursor_x is meaningful.
REQ-010 hit_mask  output  32  per-slot overlap result of the last completed scan.
REQ-011 hit_valid  output  1  one-cycle pulse; hit_mask and score just updated.
REQ-012 score  output  16  accumulated hit count, saturating.
REQ-013 busy  output  1  high in ARM and SCAN.

Function
REQ-014 Aligned slot = (slot_cnt - 1) mod 32, 5 bits; 6'd0 maps to slot 31.
REQ-015 States: IDLE, ARM, SCAN, REPORT.
REQ-016 IDLE -> ARM on frame_start; cursor_x and cursor_valid latched that cycle.
REQ-017 ARM -> SCAN on the first cycle with aligned slot == 0; that sample is scanned.
REQ-018 SCAN samples exactly 32 consecutive cycles, slots 0..31; after slot 31 -> REPORT.
REQ-019 Slot s overlaps iff latched cursor_valid, note_x != 0, and |note_x - latched cursor_x| <= TOL.
REQ-020 The difference uses 11-bit unsigned magnitude; no wrap-around.
REQ-021 Overlap bits go into a scratch mask; hit_mask changes only in REPORT.
REQ-022 REPORT lasts one cycle: hit_mask <= scratch, hit_valid = 1, score updated, then -> IDLE.
REQ-023 Latency: hit_valid asserts the cycle after slot 31 is sampled.
REQ-024 score adds popcount of new hits (see REQ-030); saturates at 16'hFFFF.
REQ-025 frame_start outside IDLE is ignored; no queueing.
REQ-026 frame_start in REPORT is ignored; the next scan needs a later pulse in IDLE.
REQ-027 Latched cursor_valid = 0: the scan still runs; result is an all-zero mask, score unchanged.

Reset
REQ-028 rst at any state, mid-scan included, forces IDLE the next cycle and discards the scratch mask.
REQ-029 Reset values: hit_mask = 0, hit_valid = 0, score = 0, busy = 0; latched cursor = 0/invalid.

Configuration
REQ-030 Macro NOTE_HIT_EDGE_EN defined: new hits = scratch & ~hit_mask (each note scored once while held).
REQ-031 Macro NOTE_HIT_EDGE_EN undefined: new hits = scratch; each overlapping slot scores every scan.

Structure
REQ-032 Shared package note_pkg holds: state enum, N_SLOTS, NOTE_XW = 10, SCORE_W = 16, NOTE_INACTIVE = 10'd0.
REQ-033 Sub-module popcount32 (combinational, 32-bit in, 6-bit out) is used for the score increment.

Verification
REQ-034 cursor_x = 200, valid, slot 5 note_x = 210, others 0, frame_start -> hit_valid once, hit_mask = 32'h20, score = 1.
REQ-035 Same stimulus twice -> score = 1 with NOTE_HIT_EDGE_EN defined, 2 without it.
REQ-036 note_x = 216 and 217 with cursor_x = 200 -> first overlaps, second does not.
REQ-037 cursor_x = 5, note_x = 1020 -> no overlap (no wrap); cursor_valid = 0 -> mask 0, hit_valid still pulses.
REQ-038 rst asserted at slot 12 of SCAN -> IDLE next cycle, no hit_valid, all outputs at reset values.
REQ-039 Score preset to 16'hFFFE, 3 new hits -> score = 16'hFFFF; frame_start during SCAN -> only one hit_valid.
